// File: rtl/spi_pkg.sv
// Types and default constants shared by the SPI master and the sample-receiving slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } spi_state_t;

  localparam int SPI_WIDTH    = 32;
  localparam int SPI_CLK_DIV  = 4;
  localparam int SPI_IDLE_GAP = 2;

endpackage

// File: rtl/spi_master_if.sv
// Core-side handshake plus board-side SPI pins of the master, grouped as one bundle.
// start is taken only while ready=1; done is a one-cycle strobe marking rx_data valid.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             sck;
  logic             sdo;
  logic             sdi;
  logic             ss_n;

  modport master (
    input  start, tx_data, sdi,
    output ready, busy, done, rx_data, sck, sdo, ss_n
  );

  modport slave (
    output start, tx_data, sdi,
    input  ready, busy, done, rx_data, sck, sdo, ss_n
  );

endinterface

// File: rtl/spi_clk_gen.sv
// sck divider: toggles sck every CLK_DIV enabled cycles and flags which edge is coming.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sck,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div_cnt;
  logic          r_sck;
  logic          w_tick;

  assign w_tick      = i_en && (r_div_cnt == DW'(CLK_DIV - 1));
  assign o_rise_tick = w_tick && !r_sck;
  assign o_fall_tick = w_tick && r_sck;
  assign o_sck       = r_sck;

  // Disabled means parked: counter at zero and sck low, so every entry starts a fresh half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: shifts a WIDTH-bit word out MSB-first on sdo while capturing sdi.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_WIDTH,
  parameter int CLK_DIV  = SPI_CLK_DIV,
  parameter int IDLE_GAP = SPI_IDLE_GAP
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_if.master      bus,
  output spi_state_t        o_dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  spi_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_tx_sh, r_rx_sh, r_rx_data;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             w_busy, w_accept, w_last_fall;
  logic             w_sck, w_rise_tick, w_fall_tick;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_busy),
    .i_clr       (r_state == IDLE),
    .o_sck       (w_sck),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  assign w_busy      = (r_state == SETUP) || (r_state == SHIFT);
  assign w_accept    = (r_state == IDLE) && bus.start;
  assign w_last_fall = w_fall_tick && (r_bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = SETUP;
      SETUP:   if (w_rise_tick) w_next = SHIFT;
      SHIFT:   if (w_last_fall) w_next = DONE;
      DONE:    w_next = (IDLE_GAP == 0) ? IDLE : GAP;
      GAP:     if (r_gap_cnt == GW'(IDLE_GAP - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first rise happens on leaving SETUP; sampling there too yields WIDTH captured bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_tx_sh   <= bus.tx_data;
      r_rx_sh   <= '0;
      r_bit_cnt <= '0;
    end else if (w_rise_tick) begin
      r_rx_sh   <= {r_rx_sh[WIDTH-2:0], bus.sdi};
    end else if (w_fall_tick) begin
      r_tx_sh   <= {r_tx_sh[WIDTH-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_last_fall) r_rx_data <= r_rx_sh;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_gap_cnt <= '0;
    else if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
    else                     r_gap_cnt <= '0;
  end

  // tx_sh is fully zero-filled after WIDTH shifts, so sdo reads 0 outside a frame.
  assign bus.sdo     = r_tx_sh[WIDTH-1];
  assign bus.sck     = w_sck;
  assign bus.ss_n    = !w_busy;
  assign bus.busy    = w_busy;
  assign bus.ready   = (r_state == IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.rx_data = r_rx_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default 32-bit instance plus a WIDTH=10, CLK_DIV=2 instance.
module tb_spi_master;
  import spi_pkg::*;

  localparam int W   = 32;
  localparam int CD  = 4;
  localparam int IG  = 2;
  localparam int W2  = 10;
  localparam int CD2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_master_if #(.WIDTH(W))  if_a ();
  spi_master_if #(.WIDTH(W2)) if_b ();
  spi_state_t dbg_a, dbg_b;

  spi_master #(.WIDTH(W), .CLK_DIV(CD), .IDLE_GAP(IG)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.master), .o_dbg_state(dbg_a)
  );
  spi_master #(.WIDTH(W2), .CLK_DIV(CD2), .IDLE_GAP(IG)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.master), .o_dbg_state(dbg_b)
  );

  // Slave model: presents its MSB while selected, shifts on every sck fall.
  bit          use_slave = 1'b0;
  logic [31:0] slave_sh  = '0;
  always @(negedge if_a.sck) if (!if_a.ss_n) slave_sh = {slave_sh[30:0], 1'b0};
  assign if_a.sdi = use_slave ? slave_sh[31] : if_a.sdo;
  assign if_b.sdi = if_b.sdo;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitors (sampled on falling clk) ----------------
  int acc_q[$];
  int done_q[$];
  int done_cnt = 0, rise_cnt = 0, ssn_low_cnt = 0, bad_edge = 0, first_rise = -1;
  logic [31:0] sdo_cap = '0;
  logic prev_sck_a = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (if_a.ready && if_a.start) acc_q.push_back(cyc + 1);
      if (!if_a.ss_n) ssn_low_cnt++;
      if (if_a.ss_n && if_a.sck) bad_edge++;
      if (if_a.sck && !prev_sck_a) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = cyc;
        sdo_cap = {sdo_cap[30:0], if_a.sdo};
      end
      if (if_a.done) begin
        done_cnt++;
        done_q.push_back(cyc);
        check("done_ss_n", 32'(if_a.ss_n), 32'd1);
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("rx_data", if_a.rx_data, exp_q.pop_front());
      end
    end
    prev_sck_a = if_a.sck;
  end

  int b_done_cnt = 0, b_done_cyc = -1, b_rise_cnt = 0, b_last_rise = -1;
  int b_per_min = 1000, b_per_max = 0;
  logic [W2-1:0] b_rx = '0;
  logic prev_sck_b = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (if_b.sck && !prev_sck_b) begin
        b_rise_cnt++;
        if (b_last_rise >= 0) begin
          if (cyc - b_last_rise < b_per_min) b_per_min = cyc - b_last_rise;
          if (cyc - b_last_rise > b_per_max) b_per_max = cyc - b_last_rise;
        end
        b_last_rise = cyc;
      end
      if (if_b.done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
        b_rx = if_b.rx_data;
      end
    end
    prev_sck_b = if_b.sck;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    acc_q.delete();
    done_q.delete();
    done_cnt = 0; rise_cnt = 0; ssn_low_cnt = 0; first_rise = -1; sdo_cap = '0;
  endtask

  // Returns #1 after the acceptance edge E0.
  task automatic start_frame(input logic [31:0] tx, input bit slave, input logic [31:0] sw);
    int n = 0;
    while (!if_a.ready && n < 1000) begin @(posedge clk); #1; n++; end
    check("ready_timeout", 32'(n < 1000), 32'd1);
    use_slave    = slave;
    slave_sh     = sw;
    clear_stats();
    if_a.tx_data = tx;
    if_a.start   = 1'b1;
    @(posedge clk); #1;
    if_a.start   = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin @(posedge clk); #1; n++; end
    check("done_timeout", 32'(n < limit), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] tx);
    check({tag, "_accepts"}, 32'(acc_q.size()), 32'd1);
    check({tag, "_dones"}, 32'(done_cnt), 32'd1);
    if (acc_q.size() > 0 && done_q.size() > 0) begin
      check({tag, "_done_ofs"}, 32'(done_q[0] - acc_q[0]), 32'(2 * W * CD));
      check({tag, "_rise1_ofs"}, 32'(first_rise - acc_q[0]), 32'(CD));
    end
    check({tag, "_rises"}, 32'(rise_cnt), 32'(W));
    check({tag, "_sdo_stream"}, sdo_cap, tx);
    check({tag, "_ssn_low"}, 32'(ssn_low_cnt), 32'(2 * W * CD));
  endtask

  typedef struct {
    logic [31:0] tx;
    bit          slave;
    logic [31:0] sw;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{32'hA5C3_0F81, 1'b0, 32'h0,         32'hA5C3_0F81};
    vecs[1] = '{32'h1234_5678, 1'b1, 32'h0000_03FF, 32'h0000_03FF};
    vecs[2] = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 32'h0,         32'hFFFF_FFFF};
    vecs[4] = '{32'h8000_0001, 1'b1, 32'hF0F0_F0F0, 32'hF0F0_F0F0};

    reset = 1'b1;
    if_a.start = 1'b0; if_a.tx_data = '0;
    if_b.start = 1'b0; if_b.tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(if_a.ready), 32'd1);
    check("rst_busy",  32'(if_a.busy),  32'd0);
    check("rst_ss_n",  32'(if_a.ss_n),  32'd1);
    check("rst_sck",   32'(if_a.sck),   32'd0);
    check("rst_sdo",   32'(if_a.sdo),   32'd0);
    check("rst_done",  32'(if_a.done),  32'd0);
    check("rst_rx",    if_a.rx_data,    32'd0);
    check("rst_state", 32'(dbg_a),      32'(IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_rx);
      start_frame(vecs[i].tx, vecs[i].slave, vecs[i].sw);
      wait_dones(1, 400);
      repeat (5) @(posedge clk);
      #1;
      check_frame($sformatf("vec%0d", i), vecs[i].tx);
      check($sformatf("vec%0d_ready_after", i), 32'(if_a.ready), 32'd1);
    end

    // Start pulse in mid-frame must be dropped.
    exp_q.push_back(32'hA5C3_0F81);
    start_frame(32'hA5C3_0F81, 1'b0, 32'h0);
    repeat (49) @(posedge clk);
    #1;
    if_a.tx_data = 32'hFFFF_FFFF;
    if_a.start   = 1'b1;
    @(posedge clk); #1;
    if_a.start   = 1'b0;
    wait_dones(1, 400);
    repeat (10) @(posedge clk);
    #1;
    check_frame("busy_start", 32'hA5C3_0F81);

    // Back-to-back with start held high.
    exp_q.push_back(32'h0F0F_1234);
    exp_q.push_back(32'h0F0F_1234);
    start_frame(32'h0F0F_1234, 1'b0, 32'h0);
    acc_q.delete();
    acc_q.push_back(cyc);
    if_a.start = 1'b1;
    begin
      int n = 0;
      while (acc_q.size() < 2 && n < 700) begin @(posedge clk); #1; n++; end
      check("b2b_second_accept", 32'(n < 700), 32'd1);
    end
    if_a.start = 1'b0;
    wait_dones(2, 400);
    repeat (5) @(posedge clk);
    #1;
    check("b2b_dones", 32'(done_cnt), 32'd2);
    check("b2b_rises", 32'(rise_cnt), 32'(2 * W));
    if (acc_q.size() >= 2 && done_q.size() >= 1) begin
      check("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(2 * W * CD + 1 + IG + 1));
      check("b2b_done_to_accept", 32'(acc_q[1] - done_q[0]), 32'(IG + 2));
    end

    // Asynchronous reset in mid-frame.
    exp_q.push_back(32'hC0FF_EE11);
    start_frame(32'hC0FF_EE11, 1'b0, 32'h0);
    repeat (99) @(posedge clk);
    #1;
    check("mid_ss_n_low", 32'(if_a.ss_n), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_sck",   32'(if_a.sck),   32'd0);
    check("mid_rst_ss_n",  32'(if_a.ss_n),  32'd1);
    check("mid_rst_busy",  32'(if_a.busy),  32'd0);
    check("mid_rst_rx",    if_a.rx_data,    32'd0);
    check("mid_rst_ready", 32'(if_a.ready), 32'd1);
    check("mid_rst_state", 32'(dbg_a),      32'(IDLE));
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h5A5A_C3C3);
    start_frame(32'h5A5A_C3C3, 1'b0, 32'h0);
    wait_dones(1, 400);
    repeat (5) @(posedge clk);
    #1;
    check_frame("post_rst", 32'h5A5A_C3C3);
    check("bad_sck_edges", 32'(bad_edge), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Narrow, fast instance.
    begin
      int acc_b;
      int n = 0;
      check("b_ready", 32'(if_b.ready), 32'd1);
      if_b.tx_data = 10'h2AA;
      if_b.start   = 1'b1;
      @(posedge clk); #1;
      acc_b = cyc;
      if_b.start   = 1'b0;
      while (b_done_cnt == 0 && n < 200) begin @(posedge clk); #1; n++; end
      check("b_done_timeout", 32'(n < 200), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("b_done_ofs", 32'(b_done_cyc - acc_b), 32'(2 * W2 * CD2));
      check("b_rx", 32'(b_rx), 32'h2AA);
      check("b_rises", 32'(b_rise_cnt), 32'(W2));
      check("b_per_min", 32'(b_per_min), 32'(2 * CD2));
      check("b_per_max", 32'(b_per_max), 32'(2 * CD2));
      check("b_dones", 32'(b_done_cnt), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
